// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and widths for the register-file writeback port arbiter.
package wb_port_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 64;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dst;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: scalar request, secondary result stream, register-file write.
interface wb_port_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                                      wb_valid;
    logic [wb_port_arbiter_pkg::REG_ADDR_W-1:0] wb_dst;
    logic [wb_port_arbiter_pkg::XLEN-1:0]       wb_data;
    logic                                      lr_valid;
    logic [wb_port_arbiter_pkg::REG_ADDR_W-1:0] lr_dst;
    logic [wb_port_arbiter_pkg::XLEN-1:0]       lr_data;
    logic                                      lr_ready;
    logic                                      pipe_stall;
    logic                                      rf_we;
    logic [wb_port_arbiter_pkg::REG_ADDR_W-1:0] rf_waddr;
    logic [wb_port_arbiter_pkg::XLEN-1:0]       rf_wdata;
    logic [CNT_W-1:0]                          fifo_count;

    modport master (
        output wb_valid, wb_dst, wb_data, lr_valid, lr_dst, lr_data,
        input  lr_ready, pipe_stall, rf_we, rf_waddr, rf_wdata, fifo_count
    );

    modport slave (
        input  wb_valid, wb_dst, wb_data, lr_valid, lr_dst, lr_data,
        output lr_ready, pipe_stall, rf_we, rf_waddr, rf_wdata, fifo_count
    );
endinterface

// File: rtl/wb_sync_fifo.sv
// Synchronous FIFO of secondary writeback entries; head is read combinationally.
module wb_sync_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        push,
    input  wb_entry_t                   wr_entry,
    input  logic                        pop,
    output wb_entry_t                   head,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between scalar WB and buffered secondary results.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    wb_port_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] count;
    logic [3:0]       starve_cnt;
    wb_entry_t        head;
    wb_entry_t        in_entry;
    wb_req_t          scalar;
    logic             nonempty;
    logic             push;
    logic             sec_grant;

    assign scalar   = '{valid: bus.wb_valid, dst: bus.wb_dst, data: bus.wb_data};
    assign in_entry = '{dst: bus.lr_dst, data: bus.lr_data};

    assign nonempty  = (count != '0);
    assign bus.lr_ready = (count != CNT_W'(DEPTH));
    assign push      = bus.lr_valid && bus.lr_ready;
    assign sec_grant = nonempty && (!scalar.valid || starve_cnt == 4'(MAX_WAIT));

    assign bus.pipe_stall = scalar.valid && sec_grant;
    assign bus.fifo_count = count;

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        if (sec_grant) begin
            bus.rf_we    = (head.dst != '0);
            bus.rf_waddr = head.dst;
            bus.rf_wdata = head.data;
        end else if (scalar.valid) begin
            bus.rf_we    = (scalar.dst != '0);
            bus.rf_waddr = scalar.dst;
            bus.rf_wdata = scalar.data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (!nonempty || sec_grant) begin
            starve_cnt <= '0;
        end else if (starve_cnt != 4'(MAX_WAIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    wb_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .wr_entry (in_entry),
        .pop      (sec_grant),
        .head     (head),
        .count    (count)
    );
endmodule
